// File: rtl/ctrl_decoder_pkg.sv
// Shared constants and types for the ctrl_decoder instruction-sequencing controller:
// opcode/sub-opcode values, mux select encodings, FSM state encoding and the
// decoded-control bundle passed from instr_decode to ctrl_decoder.
package ctrl_pkg;

    // Major opcodes, instr[30:25]
    localparam logic [5:0] OP_ALU  = 6'b100000;
    localparam logic [5:0] OP_MOVI = 6'b100010;
    localparam logic [5:0] OP_ADDI = 6'b101000;
    localparam logic [5:0] OP_ORI  = 6'b101100;
    localparam logic [5:0] OP_XORI = 6'b101011;

    // ALU sub-opcodes, instr[4:0]
    localparam logic [4:0] SUB_ADD   = 5'b00000;
    localparam logic [4:0] SUB_SUB   = 5'b00001;
    localparam logic [4:0] SUB_AND   = 5'b00010;
    localparam logic [4:0] SUB_XOR   = 5'b00011;
    localparam logic [4:0] SUB_OR    = 5'b00100;
    localparam logic [4:0] SUB_SLLI  = 5'b01000;
    localparam logic [4:0] SUB_SRLI  = 5'b01001;
    localparam logic [4:0] SUB_ROTRI = 5'b01011;

    // Immediate extension select
    localparam logic [1:0] imm5bitZE  = 2'b00;
    localparam logic [1:0] imm15bitSE = 2'b01;
    localparam logic [1:0] imm15bitZE = 2'b10;
    localparam logic [1:0] imm20bitSE = 2'b11;

    // ALU operand 2 select
    localparam logic regOut = 1'b0;
    localparam logic immOut = 1'b1;

    // Writeback source select
    localparam logic aluResult = 1'b0;
    localparam logic scr2      = 1'b1;

    // FSM state encoding
    localparam logic [1:0] STOP      = 2'd0;
    localparam logic [1:0] FETCH     = 2'd1;
    localparam logic [1:0] EXECUTE   = 2'd2;
    localparam logic [1:0] WRITEBACK = 2'd3;

    // Everything the datapath needs for one instruction
    typedef struct packed {
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rt;
        logic [4:0]  imm5;
        logic [14:0] imm15;
        logic [19:0] imm20;
        logic [1:0]  mux4to1;
        logic        mux2to1;
        logic        imm_reg;
        logic [5:0]  opcode;
        logic [4:0]  sub_opcode;
        logic        illegal;
    } decode_t;

    // Register-register ALU operations
    function automatic logic is_alu_reg_sub(input logic [4:0] s);
        return (s == SUB_ADD) || (s == SUB_SUB) || (s == SUB_AND) ||
               (s == SUB_XOR) || (s == SUB_OR);
    endfunction

    // Shift/rotate-by-immediate ALU operations
    function automatic logic is_alu_shift_sub(input logic [4:0] s);
        return (s == SUB_SLLI) || (s == SUB_SRLI) || (s == SUB_ROTRI);
    endfunction

    // Harmless control set substituted for an undecodable instruction
    function automatic decode_t nop_decode();
        decode_t d;
        d            = '0;
        d.opcode     = OP_ALU;
        d.sub_opcode = SUB_SRLI;
        d.mux4to1    = imm5bitZE;
        d.imm_reg    = immOut;
        d.mux2to1    = aluResult;
        d.illegal    = 1'b1;
        return d;
    endfunction

endpackage

// File: rtl/ctrl_decoder_if.sv
// Instruction handshake and datapath control bundle for ctrl_decoder.
// master: instruction source / datapath side. slave: the controller.
interface ctrl_decoder_if #(
    parameter int DataSize = 32,
    parameter int AddrSize = 5
);
    logic [DataSize-1:0] instr;
    logic                instr_valid;
    logic                instr_ready;
    logic                alu_overflow;
    logic [AddrSize-1:0] read_address1;
    logic [AddrSize-1:0] read_address2;
    logic [AddrSize-1:0] write_address;
    logic [4:0]          imm_5bit;
    logic [14:0]         imm_15bit;
    logic [19:0]         imm_20bit;
    logic [1:0]          mux4to1_select;
    logic                mux2to1_select;
    logic                imm_reg_select;
    logic                enable_fetch;
    logic                enable_execute;
    logic                enable_writeback;
    logic [5:0]          opcode;
    logic [4:0]          sub_opcode;
    logic                illegal;
    logic                ovf_sticky;

    modport master (
        output instr, instr_valid, alu_overflow,
        input  instr_ready, read_address1, read_address2, write_address,
               imm_5bit, imm_15bit, imm_20bit, mux4to1_select, mux2to1_select,
               imm_reg_select, enable_fetch, enable_execute, enable_writeback,
               opcode, sub_opcode, illegal, ovf_sticky
    );

    modport slave (
        input  instr, instr_valid, alu_overflow,
        output instr_ready, read_address1, read_address2, write_address,
               imm_5bit, imm_15bit, imm_20bit, mux4to1_select, mux2to1_select,
               imm_reg_select, enable_fetch, enable_execute, enable_writeback,
               opcode, sub_opcode, illegal, ovf_sticky
    );
endinterface

// File: rtl/ctrl_decoder_instr_decode.sv
// Combinational NDS32-subset decoder: splits the instruction into register
// addresses and immediates and chooses the mux selects. Any undecodable word
// (instr[31] set, unknown opcode, unknown ALU sub-opcode) is replaced by a NOP
// control set with the illegal flag raised.
module instr_decode
    import ctrl_pkg::*;
#(
    parameter int DataSize = 32
) (
    input  logic [DataSize-1:0] instr,
    output decode_t             dec
);

    logic [5:0] op;
    logic [4:0] sb;

    assign op = instr[30:25];
    assign sb = instr[4:0];

    // Field extraction plus opcode-table lookup of the selects
    always_comb begin
        // NOTE: every field gets a value before any branch so no path leaves it unassigned (no latch).
        dec            = '0;
        dec.ra         = instr[19:15];
        dec.rb         = instr[14:10];
        dec.rt         = instr[24:20];
        dec.imm5       = instr[14:10];
        dec.imm15      = instr[14:0];
        dec.imm20      = instr[19:0];
        dec.opcode     = op;
        dec.sub_opcode = sb;

        if (instr[31]) begin
            dec.illegal = 1'b1;
        end else begin
            case (op)
                OP_ALU: begin
                    if (is_alu_reg_sub(sb)) begin
                        dec.mux4to1 = imm5bitZE;
                        dec.imm_reg = regOut;
                        dec.mux2to1 = aluResult;
                    end else if (is_alu_shift_sub(sb)) begin
                        dec.mux4to1 = imm5bitZE;
                        dec.imm_reg = immOut;
                        dec.mux2to1 = aluResult;
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end
                OP_MOVI: begin
                    dec.mux4to1 = imm20bitSE;
                    dec.imm_reg = immOut;
                    dec.mux2to1 = scr2;
                end
                OP_ADDI: begin
                    dec.mux4to1 = imm15bitSE;
                    dec.imm_reg = immOut;
                    dec.mux2to1 = aluResult;
                end
                OP_ORI, OP_XORI: begin
                    dec.mux4to1 = imm15bitZE;
                    dec.imm_reg = immOut;
                    dec.mux2to1 = aluResult;
                end
                default: dec.illegal = 1'b1;
            endcase
        end

        if (dec.illegal) begin
            dec = nop_decode();
        end
    end

endmodule

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: accepts one instruction over valid/ready, registers its decoded
// controls and steps the datapath STOP -> FETCH -> EXECUTE -> WRITEBACK.
// Controls are held from accept until the next accept.
// Optional: CTRL_BYPASS_STOP_EN lets WRITEBACK accept the next instruction and
// go straight to FETCH (3 cycles/instruction back-to-back).
module ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter int DataSize = 32,
    parameter int AddrSize = 5
) (
    input  logic          clk,
    input  logic          rst,
    ctrl_decoder_if.slave bus
);

    logic [1:0] state;
    logic [1:0] next_state;
    logic       ready_q;
    logic       ready_next;
    logic       accept;
    logic       en_fetch_q;
    logic       en_execute_q;
    logic       en_writeback_q;
    logic       illegal_q;
    logic       ovf_q;
    decode_t    dec;
    decode_t    dec_q;

    instr_decode #(.DataSize(DataSize)) u_decode (
        .instr (bus.instr),
        .dec   (dec)
    );

    assign accept = bus.instr_valid && ready_q;

    // Sequencing: one cycle per phase, STOP waits for an accepted instruction
    always_comb begin
        next_state = state;
        case (state)
            STOP:      if (accept) next_state = FETCH;
            FETCH:     next_state = EXECUTE;
            EXECUTE:   next_state = WRITEBACK;
`ifdef CTRL_BYPASS_STOP_EN
            WRITEBACK: next_state = accept ? FETCH : STOP;
`else
            WRITEBACK: next_state = STOP;
`endif
            default:   next_state = STOP;
        endcase
    end

    // The controller is ready in STOP (and in WRITEBACK when bypass is built in)
`ifdef CTRL_BYPASS_STOP_EN
    assign ready_next = (next_state == STOP) || (next_state == WRITEBACK);
`else
    assign ready_next = (next_state == STOP);
`endif

    // State, ready and one-hot enables, all registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= STOP;
            ready_q        <= 1'b0;
            en_fetch_q     <= 1'b0;
            en_execute_q   <= 1'b0;
            en_writeback_q <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state          <= next_state;
            ready_q        <= ready_next;
            en_fetch_q     <= (next_state == FETCH);
            en_execute_q   <= (next_state == EXECUTE);
            en_writeback_q <= (next_state == WRITEBACK) && !dec_q.illegal;
            illegal_q      <= accept && dec.illegal;
        end
    end

    // Sticky overflow: latched from the ALU only while executing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if ((state == EXECUTE) && bus.alu_overflow) begin
            ovf_q <= 1'b1;
        end
    end

    // Decoded control bundle, captured at accept and held for the instruction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: this wide register is reset on purpose so no stale control reaches the datapath after reset.
            dec_q <= '0;
        end else if (accept) begin
            dec_q <= dec;
        end
    end

    assign bus.instr_ready      = ready_q;
    assign bus.read_address1    = AddrSize'(dec_q.ra);
    assign bus.read_address2    = AddrSize'(dec_q.rb);
    assign bus.write_address    = AddrSize'(dec_q.rt);
    assign bus.imm_5bit         = dec_q.imm5;
    assign bus.imm_15bit        = dec_q.imm15;
    assign bus.imm_20bit        = dec_q.imm20;
    assign bus.mux4to1_select   = dec_q.mux4to1;
    assign bus.mux2to1_select   = dec_q.mux2to1;
    assign bus.imm_reg_select   = dec_q.imm_reg;
    assign bus.opcode           = dec_q.opcode;
    assign bus.sub_opcode       = dec_q.sub_opcode;
    assign bus.enable_fetch     = en_fetch_q;
    assign bus.enable_execute   = en_execute_q;
    assign bus.enable_writeback = en_writeback_q;
    assign bus.illegal          = illegal_q;
    assign bus.ovf_sticky       = ovf_q;

endmodule

// File: tb/tb_ctrl_decoder.sv
// Self-checking bench for ctrl_decoder. A transaction-level model (phase counter
// since accept plus a table-driven decode) predicts every output each cycle;
// directed vectors add hand-computed literal expectations.
// Honours CTRL_BYPASS_STOP_EN when the design is built with it.
`timescale 1ns/1ps
module tb_ctrl_decoder;

`ifdef CTRL_BYPASS_STOP_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ctrl_decoder_if #(.DataSize(32), .AddrSize(5)) bus ();

    ctrl_decoder #(.DataSize(32), .AddrSize(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        ill;
        logic [4:0]  rt, ra, rb, imm5;
        logic [14:0] imm15;
        logic [19:0] imm20;
        logic [1:0]  mux4;
        logic        mux2, immsel;
        logic [5:0]  op;
        logic [4:0]  sub;
    } exp_t;

    // Decode straight from the instruction-set table
    function automatic exp_t spec_decode(input logic [31:0] w);
        exp_t e;
        logic [5:0] op;
        logic [4:0] sb;
        op = w[30:25];
        sb = w[4:0];
        e = '0;
        e.rt = w[24:20]; e.ra = w[19:15]; e.rb = w[14:10]; e.imm5 = w[14:10];
        e.imm15 = w[14:0]; e.imm20 = w[19:0]; e.op = op; e.sub = sb;
        if (w[31]) e.ill = 1'b1;
        else if (op == 6'b100000 && sb <= 5'd4) begin e.mux4 = 2'd0; e.immsel = 1'b0; e.mux2 = 1'b0; end
        else if (op == 6'b100000 && (sb == 5'd8 || sb == 5'd9 || sb == 5'd11)) begin e.mux4 = 2'd0; e.immsel = 1'b1; e.mux2 = 1'b0; end
        else if (op == 6'b100010) begin e.mux4 = 2'd3; e.immsel = 1'b1; e.mux2 = 1'b1; end
        else if (op == 6'b101000) begin e.mux4 = 2'd1; e.immsel = 1'b1; e.mux2 = 1'b0; end
        else if (op == 6'b101100 || op == 6'b101011) begin e.mux4 = 2'd2; e.immsel = 1'b1; e.mux2 = 1'b0; end
        else e.ill = 1'b1;
        if (e.ill) begin
            e = '0;
            e.ill = 1'b1;
            e.op = 6'b100000;
            e.sub = 5'b01001;
        end
        return e;
    endfunction

    exp_t m     = '0;
    int   m_cnt = 0;      // 0 idle, 1..3 = cycles since accept
    bit   m_live = 1'b0;  // a clock edge has been seen out of reset
    bit   m_ovf = 1'b0;

    function automatic bit model_ready();
        return m_live && ((m_cnt == 0) || (BYPASS && m_cnt == 3));
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m = '0; m_cnt = 0; m_live = 1'b0; m_ovf = 1'b0;
        end else begin
            bit rdy;
            rdy = model_ready();
            if (m_cnt == 2 && bus.alu_overflow) m_ovf = 1'b1;
            if (bus.instr_valid && rdy) begin
                m = spec_decode(bus.instr);
                m_cnt = 1;
            end else if (m_cnt == 3) m_cnt = 0;
            else if (m_cnt > 0) m_cnt = m_cnt + 1;
            m_live = 1'b1;
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        check("ready",   bus.instr_ready, model_ready());
        check("en_f",    bus.enable_fetch, m_cnt == 1);
        check("en_e",    bus.enable_execute, m_cnt == 2);
        check("en_w",    bus.enable_writeback, (m_cnt == 3) && !m.ill);
        check("illegal", bus.illegal, (m_cnt == 1) && m.ill);
        check("ovf",     bus.ovf_sticky, m_ovf);
        check("addrs",   {bus.write_address, bus.read_address1, bus.read_address2}, {m.rt, m.ra, m.rb});
        check("imms",    {bus.imm_5bit, bus.imm_20bit}, {m.imm5, m.imm20});
        check("imm15",   bus.imm_15bit, m.imm15);
        check("op_sub",  {bus.opcode, bus.sub_opcode}, {m.op, m.sub});
        if (!m.ill)
            check("selects", {bus.mux4to1_select, bus.imm_reg_select, bus.mux2to1_select}, {m.mux4, m.immsel, m.mux2});
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; returns at the negedge of the FETCH cycle
    task automatic send(input logic [31:0] w, input bit release_valid, output time t_acc);
        int n;
        bus.instr = w;
        bus.instr_valid = 1'b1;
        n = 0;
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL accept_timeout: instr %0h not accepted within %0d cycles", w, n);
        end
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        if (release_valid) bus.instr_valid = 1'b0;
    endtask

    logic [31:0] bad_vec [4] = '{32'h40000005, 32'hC40000C8, 32'h40000007, 32'h5A000000};
    time t1, t2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instr = '0; bus.instr_valid = 1'b0; bus.alu_overflow = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", bus.instr_ready, 0);
        check("rst_enables", {bus.enable_fetch, bus.enable_execute, bus.enable_writeback}, 0);
        #2 rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", bus.instr_ready, 1);

        // MOVI R0,200
        send(32'h440000C8, 1'b1, t1);
        check("movi_en_f", bus.enable_fetch, 1);
        check("movi_wa", bus.write_address, 0);
        check("movi_imm20", bus.imm_20bit, 200);
        check("movi_mux4", bus.mux4to1_select, 2'b11);
        check("movi_immreg", bus.imm_reg_select, 1);
        check("movi_mux2", bus.mux2to1_select, 1);
        check("movi_ready_busy", bus.instr_ready, 0);
        @(negedge clk);
        check("movi_en_e", {bus.enable_fetch, bus.enable_execute, bus.enable_writeback}, 3'b010);
        @(negedge clk);
        check("movi_en_w", {bus.enable_fetch, bus.enable_execute, bus.enable_writeback}, 3'b001);
        @(negedge clk);
        check("movi_ready_plus4", bus.instr_ready, 1);
        check("movi_held_imm20", bus.imm_20bit, 200);

        // ADDI R1,R0,100
        send(32'h50100064, 1'b1, t1);
        check("addi_wa", bus.write_address, 1);
        check("addi_imm15", bus.imm_15bit, 100);
        check("addi_mux4", bus.mux4to1_select, 2'b01);
        check("addi_op", bus.opcode, 6'b101000);
        repeat (3) @(negedge clk);

        // ADD R2,R0,R1
        send(32'h40200400, 1'b1, t1);
        check("add_regs", {bus.read_address1, bus.read_address2, bus.write_address}, {5'd0, 5'd1, 5'd2});
        check("add_immreg", bus.imm_reg_select, 0);
        check("add_sub", bus.sub_opcode, 5'b00000);
        repeat (3) @(negedge clk);

        // SRLI R2,R0,3
        send(32'h40200C09, 1'b1, t1);
        check("srli_imm5", bus.imm_5bit, 3);
        check("srli_immreg", bus.imm_reg_select, 1);
        check("srli_sub", bus.sub_opcode, 5'b01001);
        repeat (3) @(negedge clk);

        // Overflow while idle must not be recorded
        bus.alu_overflow = 1'b1;
        repeat (2) @(negedge clk);
        bus.alu_overflow = 1'b0;
        check("ovf_idle", bus.ovf_sticky, 0);

        // Illegal opcode with overflow during EXECUTE
        send(32'h7E000000, 1'b1, t1);
        check("ill_pulse", bus.illegal, 1);
        check("ill_nop", {bus.opcode, bus.sub_opcode}, {6'b100000, 5'b01001});
        check("ill_zero", {bus.write_address, bus.imm_20bit}, 0);
        @(negedge clk);
        check("ill_pulse_end", bus.illegal, 0);
        bus.alu_overflow = 1'b1;
        @(negedge clk);
        bus.alu_overflow = 1'b0;
        check("ill_no_wb", bus.enable_writeback, 0);
        check("ovf_set", bus.ovf_sticky, 1);
        @(negedge clk);
        check("ovf_held", bus.ovf_sticky, 1);

        // Other undecodable words
        foreach (bad_vec[i]) begin
            send(bad_vec[i], 1'b1, t1);
            check("ill_vec", bus.illegal, 1);
            repeat (3) @(negedge clk);
        end

        // ORI then XORI held valid back to back
        send(32'h58200064, 1'b0, t1);
        check("ori_mux4", bus.mux4to1_select, 2'b10);
        send(32'h56200064, 1'b1, t2);
        check("b2b_gap", 32'((t2 - t1) / 10), BYPASS ? 3 : 4);
        check("xori_fetch", bus.enable_fetch, 1);
        check("xori_mux4", bus.mux4to1_select, 2'b10);
        repeat (3) @(negedge clk);

        // Reset in the middle of EXECUTE
        send(32'h40200400, 1'b1, t1);
        @(negedge clk);
        check("pre_rst_exec", bus.enable_execute, 1);
        #2 rst = 1'b0;
        #1;
        check("rst_abort_en", {bus.enable_fetch, bus.enable_execute, bus.enable_writeback}, 0);
        check("rst_abort_ready", bus.instr_ready, 0);
        check("rst_ovf_clr", bus.ovf_sticky, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_release_ready", bus.instr_ready, 1);
        check("rst_fields_zero", {bus.write_address, bus.read_address2, bus.opcode}, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_decoder.md
Name: ctrl_decoder

Overview:
- Instruction-sequencing controller that drives the control side of `top`: register addresses, immediates, mux selects, ALU opcode/sub_opcode and the fetch/execute/writeback enables.
- Accepts one 32-bit NDS32-subset instruction over a valid/ready handshake and decodes it.
- Steps the datapath through STOP -> FETCH -> EXECUTE -> WRITEBACK, holding all decoded controls stable for the whole instruction.

Parameters:
- DataSize, 32, instruction and datapath width.
- AddrSize, 5, register-file address width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- instr  input  DataSize  instruction word.
- instr_valid  input  1  instr is valid.
- instr_ready  output  1  controller can accept an instruction.
- alu_overflow  input  1  overflow from the ALU.
- read_address1  output  AddrSize  Ra, taken from instr[19:15].
- read_address2  output  AddrSize  Rb, taken from instr[14:10].
- write_address  output  AddrSize  Rt, taken from instr[24:20].
- imm_5bit  output  5  instr[14:10].
- imm_15bit  output  15  instr[14:0].
- imm_20bit  output  20  instr[19:0].
- mux4to1_select  output  2  immediate extension: 00 imm5 ZE, 01 imm15 SE, 10 imm15 ZE, 11 imm20 SE.
- mux2to1_select  output  1  writeback source: 0 ALU result, 1 src2.
- imm_reg_select  output  1  ALU operand 2: 0 register, 1 immediate.
- enable_fetch / enable_execute / enable_writeback  output  1 each  state enables.
- opcode  output  6  instr[30:25].
- sub_opcode  output  5  instr[4:0].
- illegal  output  1  one-cycle pulse on an undecodable instruction.
- ovf_sticky  output  1  sticky ALU overflow flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = STOP; every output = 0, except instr_ready = 1 once out of reset.
  - A reset mid-instruction aborts it; no enable stays high.
- States:
  - STOP: instr_ready = 1. On instr_valid && instr_ready, register the decoded fields and go to FETCH.
  - FETCH -> EXECUTE -> WRITEBACK -> STOP, unconditionally, one cycle each.
  - Enables are one-hot registered outputs: enable_fetch high in FETCH only, enable_execute in EXECUTE only, enable_writeback in WRITEBACK only. All enables are 0 in STOP.
- instr_ready is 0 in FETCH, EXECUTE and WRITEBACK.
- Latency: 4 cycles per instruction, measured from accept to the next instr_ready.
- Decoded fields are registered at accept and held constant until the next accept.
- Decode table (opcode: mux4to1 / imm_reg / mux2to1):
  - 100000 ALU:
    - sub ADD 00000, SUB 00001, AND 00010, XOR 00011, OR 00100 -> 00 / 0 / 0.
    - sub SLLI 01000, SRLI 01001, ROTRI 01011 -> 00 / 1 / 0.
  - 100010 MOVI -> 11 / 1 / 1.
  - 101000 ADDI -> 01 / 1 / 0.
  - 101100 ORI -> 10 / 1 / 0.
  - 101011 XORI -> 10 / 1 / 0.
- Illegal instruction (any other opcode, any other ALU sub_opcode, or instr[31]=1):
  - illegal pulses in the FETCH cycle.
  - The sequence still runs, but enable_writeback is forced to 0 in WRITEBACK.
  - Controls are driven as NOP: opcode 100000, sub 01001, all addresses and immediates 0.
- ovf_sticky: set when alu_overflow=1 during EXECUTE; cleared only by reset.
- instr_valid while busy is ignored; the instruction is not consumed.

Optional Feature:
- Macro CTRL_BYPASS_STOP_EN.
- Defined:
  - instr_ready is also 1 in WRITEBACK.
  - An accept in WRITEBACK goes directly to FETCH with the new decode registered, giving 3 cycles/instr back-to-back.
  - With no accept, WRITEBACK -> STOP as normal.
- Undefined: instr_ready only in STOP; fixed 4-cycle sequence.

Decomposition:
- Package ctrl_pkg:
  - opcode constants: OP_ALU, OP_MOVI, OP_ADDI, OP_ORI, OP_XORI.
  - sub-op constants: SUB_ADD … SUB_ROTRI.
  - mux select constants: imm5bitZE, imm15bitSE, imm15bitZE, imm20bitSE, regOut, immOut, aluResult, scr2.
  - state encoding: STOP, FETCH, EXECUTE, WRITEBACK.
- One sub-module, instr_decode: purely combinational; takes instr and produces the field/select bundle plus illegal. ctrl_decoder registers that bundle and runs the FSM.

Test Plan:
- Reset mid-EXECUTE (rst low for 1 cycle) -> all enables 0 immediately; state STOP; instr_ready = 1 after release.
- instr=0x440000C8 (MOVI R0,200), valid 1 cycle:
  - write_address=0, imm_20bit=200, mux4to1=11, imm_reg=1, mux2to1=1.
  - Enables one-hot on cycles +1, +2, +3 after accept; instr_ready back at +4.
- instr=0x50100064 (ADDI R1,R0,100) -> write_address=1, imm_15bit=100, mux4to1=01, opcode=101000.
- Register-operand and shift decodes:
  - instr=0x40200400 (ADD R2,R0,R1) -> read1=0, read2=1, write=2, imm_reg=0, sub=00000.
  - instr=0x40200C09 (SRLI R2,R0,3) -> imm_5bit=3, imm_reg=1, sub=01001.
- instr=0x7E000000 (illegal) -> illegal pulse in FETCH, enable_writeback stays 0, NOP controls; alu_overflow=1 in EXECUTE -> ovf_sticky=1 and held.
- With CTRL_BYPASS_STOP_EN defined, ORI 0x58200064 followed by XORI 0x56200064 held valid:
  - Second instruction accepted in WRITEBACK; its FETCH follows directly.
  - ORI decodes to mux4to1=10.
